// File: rtl/encode_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : encode_flush_ctrl
// Brief    : Sequencer in front of the bit packer; forwards codewords, then
//            appends the end marker and zero pad so the stream ends on a
//            16-bit boundary.
// Revision : 1.0 - initial release
// ============================================================================
module encode_flush_ctrl #(
  parameter logic [12:0] END_MARK = 13'h0180,
  parameter logic [3:0]  END_LEN  = 4'd9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        start,
  input  logic        tok_valid,
  input  logic [12:0] tok_data,
  input  logic [3:0]  tok_len,
  input  logic        tok_last,
  output logic        tok_ready,
  output logic        cnt_output_enable,
  output logic [12:0] cnt_output,
  output logic [3:0]  cnt_len,
  output logic        cnt_finish,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_cnt,
  output logic [2:0]  ctrl_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_EOS  = 3'd2,
    S_PAD  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_bitpos;
  logic [15:0] r_word_cnt;
  logic        r_en_q;
  logic        r_fin;
  logic [12:0] r_out_data;
  logic [3:0]  r_out_len;

  logic        w_load;
  logic [12:0] w_ld_data;
  logic [3:0]  w_ld_len;
  logic        w_fin;
  logic        w_clear;
  logic [4:0]  w_sum;
  logic [3:0]  w_mark_pos;

  assign w_mark_pos = r_bitpos + END_LEN;
  assign w_sum      = {1'b0, r_bitpos} + {1'b0, w_ld_len};

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_ld_data = 13'd0;
    w_ld_len  = 4'd0;
    w_fin     = 1'b0;
    w_clear   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clear = 1'b1;
          w_next  = S_RUN;
        end
      end
      S_RUN: begin
        if (tok_valid) begin
          // Zero-length tokens are swallowed without touching the packer.
          if (tok_len != 4'd0) begin
            w_load    = 1'b1;
            w_ld_data = tok_data;
            w_ld_len  = tok_len;
          end
          if (tok_last) w_next = S_EOS;
        end
      end
      S_EOS: begin
        w_load    = 1'b1;
        w_ld_data = END_MARK;
        w_ld_len  = END_LEN;
        w_next    = (w_mark_pos == 4'd0) ? S_FIN : S_PAD;
      end
      S_PAD: begin
        w_load    = 1'b1;
        w_ld_data = 13'd0;
        w_ld_len  = 4'd0 - r_bitpos;
        w_next    = S_FIN;
      end
      S_FIN: begin
        w_fin  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bitpos   <= 4'd0;
      r_word_cnt <= 16'd0;
      r_en_q     <= 1'b0;
      r_fin      <= 1'b0;
      r_out_data <= 13'd0;
      r_out_len  <= 4'd0;
    end else if (ce) begin
      r_state <= w_next;
      r_en_q  <= w_load;
      r_fin   <= w_fin;
      if (w_load) begin
        r_out_data <= w_ld_data;
        r_out_len  <= w_ld_len;
        r_bitpos   <= w_sum[3:0];
        if (w_sum[4]) r_word_cnt <= r_word_cnt + 16'd1;
      end
      if (w_clear) begin
        r_bitpos   <= 4'd0;
        r_word_cnt <= 16'd0;
      end
    end
  end

  // Registered outputs are gated by ce so each is seen by the packer once.
  assign tok_ready         = (r_state == S_RUN) & ce;
  assign cnt_output_enable = r_en_q & ce;
  assign cnt_output        = r_out_data;
  assign cnt_len           = r_out_len;
  assign cnt_finish        = r_fin & ce;
  assign done              = r_fin & ce;
  assign busy              = (r_state != S_IDLE);
  assign word_cnt          = r_word_cnt;
  assign ctrl_state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_encode_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_encode_flush_ctrl
// Brief    : Directed bench for encode_flush_ctrl with a codeword-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encode_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst, ce, start, tok_valid, tok_last;
  logic [12:0] tok_data;
  logic [3:0]  tok_len;
  logic        tok_ready, cnt_output_enable, cnt_finish, busy, done;
  logic [12:0] cnt_output;
  logic [3:0]  cnt_len;
  logic [15:0] word_cnt;
  logic [2:0]  ctrl_state;

  encode_flush_ctrl dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start),
    .tok_valid(tok_valid), .tok_data(tok_data), .tok_len(tok_len), .tok_last(tok_last),
    .tok_ready(tok_ready), .cnt_output_enable(cnt_output_enable),
    .cnt_output(cnt_output), .cnt_len(cnt_len), .cnt_finish(cnt_finish),
    .busy(busy), .done(done), .word_cnt(word_cnt), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  typedef struct { logic [12:0] d; logic [3:0] l; } cw_t;

  int          checks = 0;
  int          errors = 0;
  cw_t         exp_q[$];
  cw_t         e;
  int unsigned acc_bits;
  int unsigned pres_bits;
  logic [15:0] wc_off;
  int          fin_cnt = 0;
  bit          ce_mode = 1'b0;
  logic [12:0] last_d, prev_d;
  logic [3:0]  last_l, prev_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the packer must see every nonzero token, then the marker, then
  // whatever zero pad brings the stream total to a multiple of 16.
  task automatic model_start();
    acc_bits  = 0;
    pres_bits = 0;
    wc_off    = 16'd0;
  endtask

  task automatic model_token(input logic [12:0] d, input logic [3:0] l, input logic last);
    int unsigned pad;
    if (l != 4'd0) begin
      exp_q.push_back('{d: d, l: l});
      acc_bits += l;
    end
    if (last) begin
      exp_q.push_back('{d: 13'h0180, l: 4'd9});
      pad = (16 - ((acc_bits + 9) % 16)) % 16;
      if (pad != 0) exp_q.push_back('{d: 13'd0, l: 4'(pad)});
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cnt_output_enable) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_enable", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("cw_data", 32'(cnt_output), 32'(e.d));
          chk("cw_len", 32'(cnt_len), 32'(e.l));
          pres_bits += cnt_len;
          chk("word_cnt_run", 32'(word_cnt), 32'(16'(wc_off + 16'(pres_bits / 16))));
        end
        prev_d = last_d; prev_l = last_l;
        last_d = cnt_output; last_l = cnt_len;
      end
      if (cnt_finish) begin
        fin_cnt++;
        chk("fin_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("fin_aligned", 32'(pres_bits % 16), 32'd0);
        chk("fin_word_cnt", 32'(word_cnt), 32'(16'(wc_off + 16'(pres_bits / 16))));
      end
      if (done | cnt_finish) chk("done_eq_finish", 32'(done), 32'(cnt_finish));
      if (!ce) begin
        chk("ready_ce_low", 32'(tok_ready), 32'd0);
        chk("enable_ce_low", 32'(cnt_output_enable), 32'd0);
      end
    end
  end

  initial begin
    ce = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ce_mode) ce = ~ce;
      else ce = 1'b1;
    end
  end

  task automatic wait_ce();
    for (int i = 0; i < 4; i++) begin
      if (ce) break;
      @(negedge clk);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    wait_ce();
    @(posedge clk);
    model_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [12:0] d, input logic [3:0] l, input logic last);
    tok_valid = 1'b1; tok_data = d; tok_len = l; tok_last = last;
    for (int i = 0; i < 8; i++) begin
      if (tok_ready) break;
      @(negedge clk);
    end
    if (!tok_ready) chk("tok_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    model_token(d, l, last);
    @(negedge clk);
    tok_valid = 1'b0; tok_last = 1'b0;
  endtask

  // Called on the first negedge after tok_last acceptance; counts cycles.
  task automatic wait_finish(input string name, input int exp_lat);
    int k = 1;
    while (!cnt_finish && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (exp_lat > 0) chk(name, 32'(k), 32'(exp_lat));
    else chk(name, 32'(cnt_finish), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tok_ready"}, 32'(tok_ready), 32'd0);
    chk({tag, "_enable"}, 32'(cnt_output_enable), 32'd0);
    chk({tag, "_output"}, 32'(cnt_output), 32'd0);
    chk({tag, "_len"}, 32'(cnt_len), 32'd0);
    chk({tag, "_finish"}, 32'(cnt_finish), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
    chk({tag, "_state"}, 32'(ctrl_state), 32'd0);
  endtask

  task automatic three_literals(input string tag);
    do_start();
    send(13'h041, 4'd9, 1'b0);
    send(13'h041, 4'd9, 1'b0);
    send(13'h041, 4'd9, 1'b1);
    wait_finish({tag, "_latency"}, 4);
    chk({tag, "_word_cnt"}, 32'(word_cnt), 32'd3);
    chk({tag, "_marker_data"}, 32'(prev_d), 32'h180);
    chk({tag, "_marker_len"}, 32'(prev_l), 32'd9);
    chk({tag, "_pad_data"}, 32'(last_d), 32'd0);
    chk({tag, "_pad_len"}, 32'(last_l), 32'd12);
  endtask

  initial begin
    int lens[10] = '{5, 13, 1, 8, 12, 3, 7, 9, 2, 11};
    int fin_before;
    rst = 1'b1; start = 1'b0; tok_valid = 1'b0; tok_last = 1'b0;
    tok_data = 13'd0; tok_len = 4'd0;
    last_d = 13'd0; last_l = 4'd0; prev_d = 13'd0; prev_l = 4'd0;
    model_start();
    @(negedge clk); @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    three_literals("lit3");

    @(negedge clk);
    do_start();
    send(13'h055, 4'd7, 1'b1);
    wait_finish("nopad_latency", 3);
    chk("nopad_word_cnt", 32'(word_cnt), 32'd1);
    chk("nopad_marker_len", 32'(last_l), 32'd9);

    @(negedge clk);
    ce_mode = 1'b1;
    do_start();
    for (int i = 0; i < 10; i++)
      send(13'((i * 37 + 5) & ((1 << lens[i]) - 1)), 4'(lens[i]), (i == 9));
    wait_finish("ce_toggle_finish", 0);
    ce_mode = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("ce_toggle_word_cnt", 32'(word_cnt), 32'd5);

    do_start();
    send(13'h003, 4'd5, 1'b0);
    start = 1'b1;
    send(13'h1FFF, 4'd0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    send(13'h007, 4'd4, 1'b1);
    wait_finish("zlen_latency", 4);
    chk("zlen_word_cnt", 32'(word_cnt), 32'd2);
    chk("zlen_pad_len", 32'(last_l), 32'd14);

    @(negedge clk);
    do_start();
    send(13'h001, 4'd3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (ctrl_state == 3'd3) break;
      @(negedge clk);
    end
    chk("reached_pad", 32'(ctrl_state), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    chk_reset("rst_in_pad");
    rst = 1'b0;
    fin_before = fin_cnt;
    repeat (4) @(negedge clk);
    chk("rst_no_finish", 32'(fin_cnt), 32'(fin_before));
    three_literals("after_rst");

    @(negedge clk);
    do_start();
    for (int i = 0; i < 4096; i++)
      send(13'($urandom), 4'd13, (i == 4095));
    wait_finish("long_latency", 4);
    chk("long_word_cnt", 32'(word_cnt), 32'd3329);

    @(negedge clk);
    do_start();
    send(13'h001, 4'd13, 1'b0);
    @(posedge clk);
    #3;
    force dut.r_word_cnt = 16'hFFFF;
    release dut.r_word_cnt;
    wc_off = 16'hFFFF - 16'(pres_bits / 16);
    @(negedge clk);
    chk("wrap_preset", 32'(word_cnt), 32'hFFFF);
    send(13'h002, 4'd13, 1'b1);
    chk("wrap_to_zero", 32'(word_cnt), 32'h0000);
    wait_finish("wrap_latency", 4);
    chk("wrap_final", 32'(word_cnt), 32'h0002);

    repeat (3) @(negedge clk);
    chk("finish_count", 32'(fin_cnt), 32'd7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
